// File: rtl/cp0_irq_timer.sv
// Interrupt controller with software, hardware and count/compare timer lines.
// Selects the highest-index pending, unmasked line as the interrupt vector.
module cp0_irq_timer #(
   parameter int N_HW  = 5,
   parameter int N_TMR = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [3:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [N_HW-1:0]  hw_irq,
   input  logic             int_enable,
   output logic             irq,
   output logic [3:0]       irq_vec,
   input  logic             irq_ack,
   input  logic             eret
);

   localparam int N_LINE   = 2 + N_HW + N_TMR;
   localparam int HW_BASE  = 2;
   localparam int TMR_BASE = 2 + N_HW;

   localparam logic [3:0] A_MASK = 4'd0;
   localparam logic [3:0] A_PEND = 4'd1;
   localparam logic [3:0] A_EDGE = 4'd2;
   localparam logic [3:0] A_CLR  = 4'd3;
   localparam logic [3:0] A_TCTL = 4'd12;

   logic [N_LINE-1:0] mask;
   logic [N_LINE-1:0] pend;
   logic [N_LINE-1:0] pend_set;
   logic [N_LINE-1:0] pend_clr;
   logic [N_LINE-1:0] pend_n;
   logic [N_LINE-1:0] active;
   logic [N_HW-1:0]   edge_mode;
   logic [N_HW-1:0]   hw_q;
   logic [N_HW-1:0]   hw_rise;
   logic [N_TMR-1:0]  tmr_en;
   logic [N_TMR-1:0]  tmr_rld;
   logic [N_TMR-1:0]  tmr_hit;
   logic [N_TMR-1:0]  wr_count;
   logic [N_TMR-1:0]  wr_compare;
   logic [CNT_W-1:0]  count   [N_TMR];
   logic [CNT_W-1:0]  compare [N_TMR];
   logic [7:0]        tctl_rd;
   logic [31:0]       rd_val;
   logic              ack_ok;

   assign hw_rise = hw_irq & ~hw_q;
   assign active  = pend & mask;
   assign ack_ok  = irq_ack & irq;

   // Winning line: later iterations override earlier ones, so the highest index wins.
   // NOTE: irq_vec gets its default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      irq_vec = '0;
      for (int i = 0; i < N_LINE; i++) begin
         if (active[i]) irq_vec = 4'(i);
      end
   end

   // Gated by rst so the line stays quiet while the pending state is being cleared.
   assign irq = ~rst & (|active) & int_enable;

   always_comb begin
      for (int t = 0; t < N_TMR; t++) begin
         wr_count[t]   = we && (addr == 4'(4 + 2 * t));
         wr_compare[t] = we && (addr == 4'(5 + 2 * t));
         tmr_hit[t]    = tmr_en[t] && (count[t] == compare[t]);
      end
   end

   // NOTE: every clear source is collected first and every set source is OR-ed in last,
   // so an event arriving in the same cycle as a clear is never lost.
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (we && addr == A_PEND) begin
         pend_set[1:0] = wdata[1:0];
         pend_clr[1:0] = ~wdata[1:0];
      end
      if (eret) pend_clr[1:0] = 2'b11;
      if (we && addr == A_CLR) pend_clr = pend_clr | wdata[N_LINE-1:0];
      for (int i = 0; i < N_LINE; i++) begin
         if (ack_ok && irq_vec == 4'(i)) pend_clr[i] = 1'b1;
      end
      for (int i = 0; i < N_HW; i++) begin
         pend_set[HW_BASE + i] = edge_mode[i] & hw_rise[i];
      end
      for (int t = 0; t < N_TMR; t++) begin
         if (wr_compare[t]) pend_clr[TMR_BASE + t] = 1'b1;
         pend_set[TMR_BASE + t] = tmr_hit[t];
      end
      pend_n = (pend & ~pend_clr) | pend_set;
      // Level lines simply track the sampled input; clears cannot touch them.
      for (int i = 0; i < N_HW; i++) begin
         if (!edge_mode[i]) pend_n[HW_BASE + i] = hw_q[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask      <= '0;
         pend      <= '0;
         edge_mode <= '0;
         hw_q      <= '0;
         tmr_en    <= '0;
         tmr_rld   <= '0;
      end else begin
         hw_q <= hw_irq;
         pend <= pend_n;
         if (we && addr == A_MASK) mask <= wdata[N_LINE-1:0];
         if (we && addr == A_EDGE) edge_mode <= wdata[N_HW-1:0];
         if (we && addr == A_TCTL) begin
            tmr_en  <= wdata[N_TMR-1:0];
            tmr_rld <= wdata[4 +: N_TMR];
         end
      end
   end

   // NOTE: the timer arrays are small register banks, not RAM, so they are reset explicitly.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < N_TMR; t++) begin
            count[t]   <= '0;
            compare[t] <= '0;
         end
      end else begin
         for (int t = 0; t < N_TMR; t++) begin
            if (wr_count[t]) begin
               count[t] <= wdata[CNT_W-1:0];
            end else if (tmr_en[t]) begin
               if (tmr_hit[t] && tmr_rld[t]) count[t] <= '0;
               else                          count[t] <= count[t] + CNT_W'(1);
            end
            if (wr_compare[t]) compare[t] <= wdata[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      tctl_rd = '0;
      tctl_rd[N_TMR-1:0]  = tmr_en;
      tctl_rd[4 +: N_TMR] = tmr_rld;
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         A_MASK:  rd_val = 32'(mask);
         A_PEND:  rd_val = 32'(pend);
         A_EDGE:  rd_val = 32'(edge_mode);
         A_TCTL:  rd_val = 32'(tctl_rd);
         default: rd_val = '0;
      endcase
      for (int t = 0; t < N_TMR; t++) begin
         if (addr == 4'(4 + 2 * t)) rd_val = 32'(count[t]);
         if (addr == 4'(5 + 2 * t)) rd_val = 32'(compare[t]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else     rdata <= rd_val;
   end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Scoreboard bench for cp0_irq_timer: expected values are queued when the stimulus
// is applied and popped when the corresponding DUT output is observed.
module tb_cp0_irq_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [4:0]  hw_irq;
   logic        int_enable;
   logic        irq;
   logic [3:0]  irq_vec;
   logic        irq_ack;
   logic        eret;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] exp;

   cp0_irq_timer dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .hw_irq     (hw_irq),
      .int_enable (int_enable),
      .irq        (irq),
      .irq_vec    (irq_vec),
      .irq_ack    (irq_ack),
      .eret       (eret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0; wdata = '0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      addr = a;
      tick();
      d = rdata;
   endtask

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; hw_irq = '0;
      int_enable = 1'b0; irq_ack = 1'b0; eret = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      got = rdata; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", got, exp); end
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_irq got=%h exp=%h", got, exp); end
      for (int a = 0; a < 13; a++) begin
         exp_q.push_back(32'h0);
         rd(4'(a), got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", a, got, exp); end
      end
   endtask

   task automatic test_timer_reload();
      int cyc;
      do_reset();
      int_enable = 1'b1;
      wr(4'd5, 32'd5);
      wr(4'd0, 32'h80);
      wr(4'd12, 32'h11);
      exp_q.push_back(32'd6);
      exp_q.push_back(32'd7);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'h80);
      exp_q.push_back(32'h0);
      cyc = 0;
      while (!irq && cyc < 20) begin tick(); cyc++; end
      got = 32'(cyc); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_latency got=%0d exp=%0d", got, exp); end
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_vec got=%h exp=%h", got, exp); end
      rd(4'd4, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_reload got=%h exp=%h", got, exp); end
      rd(4'd4, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_recount got=%h exp=%h", got, exp); end
      wr(4'd12, 32'h0);
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_pend got=%h exp=%h", got, exp); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL timer_ack got=%h exp=%h", got, exp); end
   endtask

   task automatic test_edge();
      do_reset();
      int_enable = 1'b1;
      wr(4'd2, 32'h1);
      wr(4'd0, 32'h04);
      hw_irq[0] = 1'b1; tick(); hw_irq[0] = 1'b0;
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h04);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      tick(); tick(); tick();
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_vec got=%h exp=%h", got, exp); end
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_sticky got=%h exp=%h", got, exp); end
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_pend got=%h exp=%h", got, exp); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_ack_irq got=%h exp=%h", got, exp); end
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_ack_pend got=%h exp=%h", got, exp); end
   endtask

   task automatic test_level();
      do_reset();
      int_enable = 1'b1;
      wr(4'd0, 32'h08);
      hw_irq[1] = 1'b1;
      exp_q.push_back(32'h3);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      tick(); tick();
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_vec got=%h exp=%h", got, exp); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_ack_noclr got=%h exp=%h", got, exp); end
      hw_irq[1] = 1'b0;
      tick();
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_fall_1 got=%h exp=%h", got, exp); end
      tick();
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_fall_2 got=%h exp=%h", got, exp); end
   endtask

   task automatic test_priority();
      do_reset();
      int_enable = 1'b1;
      wr(4'd2, 32'h1);
      wr(4'd0, 32'h84);
      hw_irq[0] = 1'b1; tick(); hw_irq[0] = 1'b0;
      wr(4'd12, 32'h01);
      tick();
      exp_q.push_back(32'h7);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h0);
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL prio_first got=%h exp=%h", got, exp); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL prio_second got=%h exp=%h", got, exp); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL prio_drained got=%h exp=%h", got, exp); end
   endtask

   task automatic test_soft_eret();
      do_reset();
      wr(4'd1, 32'h3);
      wr(4'd0, 32'h3);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL soft_ie_off got=%h exp=%h", got, exp); end
      int_enable = 1'b1;
      #1;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL soft_ie_on got=%h exp=%h", got, exp); end
      got = 32'(irq_vec); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL soft_vec got=%h exp=%h", got, exp); end
      eret = 1'b1; tick(); eret = 1'b0;
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL soft_eret_irq got=%h exp=%h", got, exp); end
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL soft_eret_pend got=%h exp=%h", got, exp); end
   endtask

   task automatic test_set_wins();
      do_reset();
      int_enable = 1'b1;
      wr(4'd2, 32'h1);
      wr(4'd0, 32'h04);
      we = 1'b1; addr = 4'd3; wdata = 32'h4; hw_irq[0] = 1'b1;
      tick();
      we = 1'b0; wdata = '0; hw_irq[0] = 1'b0;
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h04);
      exp_q.push_back(32'h0);
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL setwin_irq got=%h exp=%h", got, exp); end
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL setwin_pend got=%h exp=%h", got, exp); end
      wr(4'd3, 32'h4);
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL clr_alone got=%h exp=%h", got, exp); end
   endtask

   task automatic test_count_write();
      do_reset();
      int_enable = 1'b1;
      wr(4'd0, 32'h80);
      wr(4'd4, 32'd3);
      wr(4'd5, 32'd4);
      wr(4'd12, 32'h01);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'd5);
      exp_q.push_back(32'd100);
      exp_q.push_back(32'h0);
      tick();
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL cnt_early got=%h exp=%h", got, exp); end
      tick();
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL cnt_match got=%h exp=%h", got, exp); end
      rd(4'd4, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL cnt_noreload got=%0d exp=%0d", got, exp); end
      wr(4'd4, 32'd100);
      rd(4'd4, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL cnt_override got=%0d exp=%0d", got, exp); end
      wr(4'd5, 32'd50);
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL cmp_wr_clear got=%h exp=%h", got, exp); end
   endtask

   task automatic test_unmapped();
      logic [3:0] addrs [3];
      addrs[0] = 4'd13; addrs[1] = 4'd6; addrs[2] = 4'd3;
      wr(4'd13, 32'hffff_ffff);
      wr(4'd6, 32'hffff_ffff);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'h0);
         rd(addrs[i], got);
         exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin failures++; $display("FAIL unmapped_%0d got=%h exp=%h", addrs[i], got, exp); end
      end
   endtask

   task automatic test_reset_midcount();
      int_enable = 1'b1;
      wr(4'd12, 32'h11);
      wr(4'd1, 32'h3);
      wr(4'd0, 32'h83);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_pre got=%h exp=%h", got, exp); end
      rst = 1'b1; irq_ack = 1'b1;
      tick();
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_in_reset got=%h exp=%h", got, exp); end
      rst = 1'b0; irq_ack = 1'b0;
      rd(4'd1, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_pend got=%h exp=%h", got, exp); end
      rd(4'd4, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_count got=%h exp=%h", got, exp); end
      got = {31'b0, irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_irq got=%h exp=%h", got, exp); end
   endtask

   initial begin
      test_reset();
      test_timer_reload();
      test_edge();
      test_level();
      test_priority();
      test_soft_eret();
      test_set_wins();
      test_count_write();
      test_unmapped();
      test_reset_midcount();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
